// File: rtl/esaxi_pkg.sv
// esaxi_pkg: shared emesh packet layout and default esaxi write-FIFO sizing
package esaxi_pkg;
    typedef struct packed {
        logic [31:0] srcaddr;
        logic [31:0] data;
        logic [31:0] dstaddr;
        logic        rsvd;
        logic [3:0]  ctrlmode;
        logic [1:0]  datamode;
        logic        write;
    } emesh_pkt_t;
    localparam int PW           = $bits(emesh_pkt_t);
    localparam int ESAXI_AW     = 3;
    localparam int ESAXI_MARGIN = 2;
endpackage

// File: rtl/esaxi_wr_fifo_if.sv
// esaxi_wr_fifo_if: esaxi write-side and emesh tx-side signals of the write FIFO
interface esaxi_wr_fifo_if
    import esaxi_pkg::*;
#(
    parameter int AW = ESAXI_AW
);
    logic          wr_access;
    logic [PW-1:0] wr_packet;
    logic          wr_wait;
    logic          tx_access;
    logic [PW-1:0] tx_packet;
    logic          tx_wait;
    logic [AW:0]   fifo_count;
    logic          overflow;
    logic [31:0]   pkt_count;
    modport master (
        output wr_access, wr_packet, tx_wait,
        input  wr_wait, tx_access, tx_packet, fifo_count, overflow, pkt_count
    );
    modport slave (
        input  wr_access, wr_packet, tx_wait,
        output wr_wait, tx_access, tx_packet, fifo_count, overflow, pkt_count
    );
endinterface

// File: rtl/esaxi_fifo_mem.sv
// esaxi_fifo_mem: unreset packet storage, one write port and one async read port
module esaxi_fifo_mem
    import esaxi_pkg::*;
#(
    parameter int AW = ESAXI_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [PW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [PW-1:0] rdata
);
    logic [PW-1:0] mem [2**AW];
    // write the accepted packet into its slot
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/esaxi_wr_fifo.sv
// esaxi_wr_fifo: elastic buffer from esaxi writes to emesh tx; ESAXI_WR_FIFO_STATS_EN adds accepted-packet counter
module esaxi_wr_fifo
    import esaxi_pkg::*;
#(
    parameter int AW     = ESAXI_AW,
    parameter int MARGIN = ESAXI_MARGIN
) (
    input logic            s_axi_aclk,
    input logic            s_axi_aresetn,
    esaxi_wr_fifo_if.slave bus
);
    localparam int          DEPTH  = 1 << AW;
    localparam logic [AW:0] FULL   = (AW + 1)'(DEPTH);
    localparam logic [AW:0] THRESH = (AW + 1)'(DEPTH - MARGIN);
    if (MARGIN < 1 || MARGIN >= DEPTH) begin : g_bad_margin
        $error("esaxi_wr_fifo: MARGIN must be in 1..DEPTH-1");
    end
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count, count_next;
    logic          push, pop, accept, wr_wait, overflow;
    assign push   = bus.wr_access;
    assign pop    = bus.tx_access & ~bus.tx_wait;
    assign accept = push & ((count != FULL) | pop);
    // occupancy after this edge; simultaneous push and pop cancel out
    always_comb
        count_next = (accept & ~pop) ? count + 1'b1 : (pop & ~accept) ? count - 1'b1 : count;
    // pointers, occupancy, early backpressure and sticky drop flag
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
        if (!s_axi_aresetn) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wr_wait  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count    <= count_next;
            wr_wait  <= count_next >= THRESH;
            overflow <= overflow | (push & ~accept);
        end
    esaxi_fifo_mem #(.AW(AW)) u_mem (
        .clk   (s_axi_aclk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (bus.wr_packet),
        .raddr (rd_ptr),
        .rdata (bus.tx_packet)
    );
    assign bus.tx_access  = count != '0;
    assign bus.fifo_count = count;
    assign bus.wr_wait    = wr_wait;
    assign bus.overflow   = overflow;
`ifdef ESAXI_WR_FIFO_STATS_EN
    logic [31:0] pkt_cnt;
    // count accepted pushes only; drops are excluded
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
        if (!s_axi_aresetn) pkt_cnt <= '0;
        else if (accept) pkt_cnt <= pkt_cnt + 1'b1;
    assign bus.pkt_count = pkt_cnt;
`else
    assign bus.pkt_count = 32'h0;
`endif
endmodule

// File: tb/tb_esaxi_wr_fifo.sv
// tb_esaxi_wr_fifo: directed and random checks of esaxi_wr_fifo against a queue model
module tb_esaxi_wr_fifo;
    import esaxi_pkg::*;
`ifdef ESAXI_WR_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [PW-1:0] q[$];
    bit ovf = 1'b0;
    int acc = 0;
    esaxi_wr_fifo_if #(.AW(3)) bus ();
    esaxi_wr_fifo #(.AW(3), .MARGIN(2)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .bus           (bus)
    );
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("tx_access", 128'(bus.tx_access), 128'(q.size() != 0));
        if (q.size() != 0) check("tx_packet", 128'(bus.tx_packet), 128'(q[0]));
        check("fifo_count", 128'(bus.fifo_count), 128'(q.size()));
        check("wr_wait", 128'(bus.wr_wait), 128'(q.size() >= 6));
        check("overflow", 128'(bus.overflow), 128'(ovf));
        check("pkt_count", 128'(bus.pkt_count), STATS ? 128'(acc) : 128'(0));
    endtask

    function automatic logic [PW-1:0] rnd_pkt();
        return PW'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    // called at a falling edge: drive inputs, advance the model, check after the next rising edge
    task automatic step(input logic wa, input logic [PW-1:0] pkt, input logic tw);
        bit pop, full, accept;
        bus.wr_access = wa;
        bus.wr_packet = pkt;
        bus.tx_wait   = tw;
        pop    = (q.size() != 0) && !tw;
        full   = q.size() == 8;
        accept = wa && (!full || pop);
        if (wa && !accept) ovf = 1'b1;
        if (pop) void'(q.pop_front());
        if (accept) begin
            q.push_back(pkt);
            acc++;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic mid_reset();
        bus.wr_access = 1'b0;
        bus.tx_wait   = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_tx_access", 128'(bus.tx_access), 128'(0));
        check("rst_wr_wait", 128'(bus.wr_wait), 128'(0));
        check("rst_count", 128'(bus.fifo_count), 128'(0));
        check("rst_overflow", 128'(bus.overflow), 128'(0));
        q.delete();
        ovf = 1'b0;
        acc = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.wr_access = 1'b0;
        bus.wr_packet = '0;
        bus.tx_wait   = 1'b0;
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0);
        step(1'b1, PW'(104'hA5), 1'b0);
        check("t2_pkt", 128'(bus.tx_packet), 128'(104'hA5));
        step(1'b0, '0, 1'b0);
        check("t2_empty", 128'(bus.fifo_count), 128'(0));
        for (int i = 0; i < 6; i++) step(1'b1, PW'(i + 16), 1'b1);
        check("t3_wait", 128'(bus.wr_wait), 128'(1));
        for (int i = 6; i < 8; i++) step(1'b1, PW'(i + 16), 1'b1);
        check("t3_full", 128'(bus.fifo_count), 128'(8));
        check("t3_no_ovf", 128'(bus.overflow), 128'(0));
        step(1'b1, PW'(104'hDEAD), 1'b1);
        check("t3_ovf", 128'(bus.overflow), 128'(1));
        check("t3_still_full", 128'(bus.fifo_count), 128'(8));
        mid_reset();
        for (int i = 0; i < 8; i++) step(1'b1, PW'(i + 32), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, PW'(i + 48), 1'b0);
        check("t4_count", 128'(bus.fifo_count), 128'(8));
        check("t4_no_ovf", 128'(bus.overflow), 128'(0));
        for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b0);
        check("t4_drained", 128'(bus.fifo_count), 128'(0));
        for (int i = 0; i < 5; i++) step(1'b1, rnd_pkt(), 1'b1);
        check("t5_count", 128'(bus.fifo_count), 128'(5));
        mid_reset();
        step(1'b1, PW'(104'h1234), 1'b1);
        check("t5_first", 128'(bus.tx_packet), 128'(104'h1234));
        mid_reset();
        for (int i = 0; i < 8; i++) step(1'b1, rnd_pkt(), 1'b1);
        step(1'b1, rnd_pkt(), 1'b1);
        for (int i = 0; i < 2; i++) step(1'b1, rnd_pkt(), 1'b0);
        check("t6_pkt_count", 128'(bus.pkt_count), STATS ? 128'(10) : 128'(0));
        mid_reset();
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 9) < 6), rnd_pkt(), 1'($urandom_range(0, 9) < 4));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
